// File: rtl/sample_ram_reader_pkg.sv
// Shared definitions for the sample RAM read path.
// - state_e   : read sequencer state encoding.
// - sum_width : width of the unsigned sweep sum (NBits + NAddr), exported so the
//               averaging/display logic can size its inputs identically.
package sample_ram_reader_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSetup = 3'd1,
    StWait  = 3'd2,
    StSend  = 3'd3,
    StDone  = 3'd4
  } state_e;

  // A full sweep of 2**naddr words of at most 2**nbits-1 fits in nbits+naddr bits.
  function automatic int unsigned sum_width(int unsigned nbits, int unsigned naddr);
    return nbits + naddr;
  endfunction

endpackage

// File: rtl/sample_ram_reader.sv
// Read-side sequencer for the accelerometer sample RAM.
// On start (sampled in IDLE) it reads count consecutive words from base_addr,
// wrapping modulo the RAM depth, allowing for the RAM's one-cycle registered read,
// streams each word on a valid/ready interface and accumulates their unsigned sum.
//
// Ports:
//   clk, rst_a        clock, synchronous active-high reset
//   start, base_addr,
//   count             sweep request; count is 0..2**NAddr
//   ram_addr          RAM read address
//   ram_wr_en         RAM write enable (active-low), tied inactive
//   ram_data          RAM registered read data
//   m_data, m_valid,
//   m_ready, m_last   downstream stream; m_last marks the final word
//   busy              high in every state except IDLE
//   done              one-cycle pulse at sweep end
//   sum               sum of the last sweep, held until the next accepted start
module sample_ram_reader
  import sample_ram_reader_pkg::*;
#(
  parameter int unsigned NBits = 7,
  parameter int unsigned NAddr = 3
) (
  input  logic                                  clk,
  input  logic                                  rst_a,
  input  logic                                  start,
  input  logic [NAddr-1:0]                      base_addr,
  input  logic [NAddr:0]                        count,
  output logic [NAddr-1:0]                      ram_addr,
  output logic                                  ram_wr_en,
  input  logic [NBits-1:0]                      ram_data,
  output logic [NBits-1:0]                      m_data,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic                                  m_last,
  output logic                                  busy,
  output logic                                  done,
  output logic [sum_width(NBits, NAddr)-1:0]    sum
);

  localparam logic [NAddr:0] CountOne = (NAddr + 1)'(1);

  state_e         state;
  logic [NAddr:0] remaining;

  // The writer side owns the RAM; this port never asserts a write.
  assign ram_wr_en = 1'b1;

  always_ff @(posedge clk) begin
    if (rst_a) begin
      state     <= StIdle;
      ram_addr  <= '0;
      remaining <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            sum  <= '0;
            busy <= 1'b1;
            if (count == '0) begin
              state <= StDone;
              done  <= 1'b1;
            end else begin
              ram_addr  <= base_addr;
              remaining <= count;
              state     <= StSetup;
            end
          end
        end
        // Address is stable; the RAM registers its output at this edge.
        StSetup: state <= StWait;
        StWait: begin
          m_data  <= ram_data;
          sum     <= sum + {{NAddr{1'b0}}, ram_data};
          m_valid <= 1'b1;
          m_last  <= (remaining == CountOne);
          state   <= StSend;
        end
        // Word is held unchanged until the downstream accepts it.
        StSend: begin
          if (m_valid && m_ready) begin
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            remaining <= remaining - CountOne;
            if (m_last) begin
              state <= StDone;
              done  <= 1'b1;
            end else begin
              ram_addr <= ram_addr + 1'b1;
              state    <= StSetup;
            end
          end
        end
        StDone: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_ram_reader.sv
module tb_sample_ram_reader;

  logic       clk = 1'b0;
  logic       rst_a;
  logic       start;
  logic [2:0] base_addr;
  logic [3:0] count;
  logic [2:0] ram_addr;
  logic       ram_wr_en;
  logic [6:0] ram_data = '0;
  logic [6:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;
  logic       busy;
  logic       done;
  logic [9:0] sum;

  int checks = 0;
  int errors = 0;

  logic [6:0] mem [8];

  typedef struct {
    logic [2:0]  base;
    logic [3:0]  cnt;
    bit          rnd;      // random 50% m_ready instead of always ready
    bit          poke;     // pulse start with other operands mid-sweep
    bit          fill127;  // preload all words to 127 instead of 1..8
    int unsigned exp_sum;
  } vec_t;

  vec_t vecs [6];

  sample_ram_reader #(.NBits(7), .NAddr(3)) dut (
    .clk       (clk),
    .rst_a     (rst_a),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .ram_addr  (ram_addr),
    .ram_wr_en (ram_wr_en),
    .ram_data  (ram_data),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .busy      (busy),
    .done      (done),
    .sum       (sum)
  );

  always #5 clk = ~clk;

  // Sample RAM model: one-cycle registered read.
  always @(posedge clk) ram_data <= mem[ram_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic write_ram(input logic [2:0] addr, input logic [6:0] data);
    mem[addr] = data;
  endtask

  task automatic preload(input bit fill127);
    for (int a = 0; a < 8; a++) write_ram(3'(a), fill127 ? 7'd127 : 7'(a + 1));
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int         beats;
    int         first_valid;
    int         done_idx;
    bit         held;
    bit         finished;
    logic [6:0] hd;
    logic       hl;
    logic [2:0] ea;
    beats = 0; first_valid = -1; done_idx = -1; held = 0; finished = 0;
    hd = '0; hl = 1'b0;
    preload(v.fill127);
    m_ready = 1'b0;
    @(negedge clk);
    start = 1'b1; base_addr = v.base; count = v.cnt;
    @(negedge clk);
    start = 1'b0;
    for (int idx = 0; idx < 400 && !finished; idx++) begin
      if (idx > 0) @(negedge clk);
      if (v.poke) begin
        if (idx == 4) begin
          start = 1'b1; base_addr = 3'd5; count = 4'd1;
        end else begin
          start = 1'b0;
        end
      end
      chk($sformatf("v%0d wr_en", id), 32'(ram_wr_en), 32'd1);
      if (held) begin
        chk($sformatf("v%0d stall valid", id), 32'(m_valid), 32'd1);
        chk($sformatf("v%0d stall data", id), 32'(m_data), 32'(hd));
        chk($sformatf("v%0d stall last", id), 32'(m_last), 32'(hl));
      end
      if (m_valid && first_valid < 0) first_valid = idx;
      if (done) begin
        done_idx = idx;
        finished = 1;
        chk($sformatf("v%0d sum", id), 32'(sum), v.exp_sum);
        chk($sformatf("v%0d busy at done", id), 32'(busy), 32'd1);
        chk($sformatf("v%0d beats", id), 32'(beats), 32'(v.cnt));
      end
      m_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_valid && m_ready) begin
        ea = v.base + 3'(beats);
        chk($sformatf("v%0d addr beat %0d", id, beats), 32'(ram_addr), 32'(ea));
        chk($sformatf("v%0d data beat %0d", id, beats), 32'(m_data), 32'(mem[ea]));
        chk($sformatf("v%0d last beat %0d", id, beats), 32'(m_last),
            32'(beats == int'(v.cnt) - 1));
        beats++;
        held = 0;
      end else if (m_valid) begin
        held = 1; hd = m_data; hl = m_last;
      end else begin
        held = 0;
      end
    end
    if (!finished) begin
      errors++;
      $display("FAIL v%0d timeout: got no done expected done", id);
    end
    chk($sformatf("v%0d first valid cycle", id), 32'(first_valid),
        (v.cnt == 0) ? 32'hffff_ffff : 32'd2);
    if (!v.rnd) chk($sformatf("v%0d done cycle", id), 32'(done_idx), 32'(3 * int'(v.cnt)));
    m_ready = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d done one cycle", id), 32'(done), 32'd0);
    chk($sformatf("v%0d busy after", id), 32'(busy), 32'd0);
    chk($sformatf("v%0d sum held", id), 32'(sum), v.exp_sum);
  endtask

  initial begin
    bit seen;
    vecs[0] = '{base: 3'd0, cnt: 4'd8, rnd: 0, poke: 0, fill127: 0, exp_sum: 36};
    vecs[1] = '{base: 3'd6, cnt: 4'd4, rnd: 0, poke: 0, fill127: 0, exp_sum: 18};
    vecs[2] = '{base: 3'd0, cnt: 4'd8, rnd: 1, poke: 0, fill127: 0, exp_sum: 36};
    vecs[3] = '{base: 3'd2, cnt: 4'd0, rnd: 0, poke: 0, fill127: 0, exp_sum: 0};
    vecs[4] = '{base: 3'd1, cnt: 4'd3, rnd: 0, poke: 1, fill127: 0, exp_sum: 9};
    vecs[5] = '{base: 3'd0, cnt: 4'd8, rnd: 0, poke: 0, fill127: 1, exp_sum: 1016};

    rst_a = 1'b1; start = 1'b0; base_addr = '0; count = '0; m_ready = 1'b0;
    preload(1'b0);
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset valid", 32'(m_valid), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset sum", 32'(sum), 32'd0);
    chk("reset addr", 32'(ram_addr), 32'd0);
    chk("reset wr_en", 32'(ram_wr_en), 32'd1);
    rst_a = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Reset while a word is waiting in SEND.
    preload(1'b0);
    m_ready = 1'b0;
    @(negedge clk);
    start = 1'b1; base_addr = 3'd3; count = 4'd8;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (m_valid) seen = 1;
      else @(negedge clk);
    end
    chk("rst seq reached send", 32'(seen), 32'd1);
    rst_a = 1'b1;
    @(negedge clk);
    chk("rst mid valid", 32'(m_valid), 32'd0);
    chk("rst mid data", 32'(m_data), 32'd0);
    chk("rst mid last", 32'(m_last), 32'd0);
    chk("rst mid busy", 32'(busy), 32'd0);
    chk("rst mid done", 32'(done), 32'd0);
    chk("rst mid sum", 32'(sum), 32'd0);
    chk("rst mid addr", 32'(ram_addr), 32'd0);
    chk("rst mid wr_en", 32'(ram_wr_en), 32'd1);
    rst_a = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post rst no done", 32'(done), 32'd0);
      chk("post rst idle", 32'(busy), 32'd0);
    end
    run_vec(6, vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
